uart_tx_ctrl: RTL and testbench

UART transmit controller directly downstream of the TX parity calculator. It accepts a parallel byte with a valid strobe and drives the serial frame on TX_OUT: start bit, data LSB-first, optional parity bit, stop bit. It exports busy, which the parity calculator uses to gate its data capture. It consumes par_bit from the parity calculator. CLK is the TX bit clock, already divided upstream, so one bit is sent per CLK cycle.

---
 rtl/uart_tx_pkg.sv | 23 ++
 rtl/uart_tx_serializer.sv | 51 +++++
 rtl/uart_tx_ctrl.sv | 116 +++++++++++
 tb/tb_uart_tx_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// ----------------------------------------------------------------------------
// uart_tx_pkg
//   Shared types and line-level constants for the UART transmit controller.
//   tx_state_e : frame sequencing states (IDLE, START, DATA, PARITY, STOP)
//   IDLE_LVL   : level of the serial line between frames
//   START_BIT  : level of the start bit
//   STOP_BIT   : level of the stop bit
// ----------------------------------------------------------------------------
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage : uart_tx_pkg

// File: rtl/uart_tx_serializer.sv
// ----------------------------------------------------------------------------
// uart_tx_serializer
//   Shift register and data-bit counter for the UART transmitter.
//   i_clk       : TX bit clock, rising edge
//   i_rst       : asynchronous reset, active-high
//   i_load      : latch i_data_in and clear the bit counter
//   i_shift_en  : shift right one bit and advance the bit counter (DATA state)
//   i_data_in   : parallel word to serialise
//   o_ser_bit   : data bit that the line carries after the coming edge
//   o_ser_done  : last data bit is being sent (counter == DATA_WD-1)
// ----------------------------------------------------------------------------
module uart_tx_serializer #(
  parameter int DATA_WD = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_shift_en,
  input  logic [DATA_WD-1:0] i_data_in,
  output logic               o_ser_bit,
  output logic               o_ser_done
);

  localparam int CNT_WD = (DATA_WD > 1) ? $clog2(DATA_WD) : 1;

  logic [DATA_WD-1:0] r_shift;
  logic [CNT_WD-1:0]  r_cnt;

  assign o_ser_done = (r_cnt == CNT_WD'(DATA_WD - 1));

  // The line register samples this before the shift lands: on the START->DATA
  // edge that is bit 0, on every DATA->DATA edge it is the bit above it.
  assign o_ser_bit = i_shift_en ? r_shift[1] : r_shift[0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_shift <= i_data_in;
      r_cnt   <= '0;
    end else if (i_shift_en) begin
      r_shift <= {1'b0, r_shift[DATA_WD-1:1]};
      // Clears on the edge that leaves DATA, so it never wraps mid-frame.
      r_cnt   <= o_ser_done ? '0 : r_cnt + CNT_WD'(1);
    end
  end

endmodule : uart_tx_serializer

// File: rtl/uart_tx_ctrl.sv
// ----------------------------------------------------------------------------
// uart_tx_ctrl
//   UART transmit controller: start bit, DATA_WD data bits LSB first,
//   optional parity bit, stop bit. One bit per CLK cycle.
//   CLK        : TX bit clock, rising edge
//   RST        : asynchronous reset, active-high
//   P_DATA     : parallel word, latched at accept
//   Data_Valid : request strobe, accepted only while busy = 0
//   PAR_EN     : insert parity bit, latched at accept
//   par_bit    : parity from the parity calculator, used in PARITY only
//   TX_OUT     : registered serial line, idles high
//   busy       : registered, high from start bit through stop bit
// ----------------------------------------------------------------------------
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WD = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [DATA_WD-1:0] P_DATA,
  input  logic               Data_Valid,
  input  logic               PAR_EN,
  input  logic               par_bit,
  output logic               TX_OUT,
  output logic               busy
);

  tx_state_e r_state;
  tx_state_e w_next_state;
  logic      r_par_en_q;
  logic      r_tx;
  logic      r_busy;
  logic      w_tx_next;
  logic      w_busy_next;
  logic      w_load;
  logic      w_shift_en;
  logic      w_ser_bit;
  logic      w_ser_done;

  assign w_load     = (r_state == IDLE) && Data_Valid;
  assign w_shift_en = (r_state == DATA);

  uart_tx_serializer #(
    .DATA_WD (DATA_WD)
  ) u_serializer (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_load     (w_load),
    .i_shift_en (w_shift_en),
    .i_data_in  (P_DATA),
    .o_ser_bit  (w_ser_bit),
    .o_ser_done (w_ser_done)
  );

  // State register, accept-time latch and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= IDLE;
      r_par_en_q <= 1'b0;
      r_tx       <= IDLE_LVL;
      r_busy     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_tx    <= w_tx_next;
      r_busy  <= w_busy_next;
      if (w_load) begin
        r_par_en_q <= PAR_EN;
      end
    end
  end

  // Next-state logic.
  // NOTE: every combinational output is given a default before the case so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = IDLE;
    case (r_state)
      IDLE:    w_next_state = Data_Valid ? START : IDLE;
      START:   w_next_state = DATA;
      DATA: begin
        if (!w_ser_done)     w_next_state = DATA;
        else if (r_par_en_q) w_next_state = PARITY;
        else                 w_next_state = STOP;
      end
      PARITY:  w_next_state = STOP;
      STOP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs decoded from the next state, so the line changes on the same
  // edge as the state.
  always_comb begin
    w_tx_next   = IDLE_LVL;
    w_busy_next = 1'b1;
    case (w_next_state)
      IDLE: begin
        w_tx_next   = IDLE_LVL;
        w_busy_next = 1'b0;
      end
      START:  w_tx_next = START_BIT;
      DATA:   w_tx_next = w_ser_bit;
      PARITY: w_tx_next = par_bit;
      STOP:   w_tx_next = STOP_BIT;
      default: begin
        w_tx_next   = IDLE_LVL;
        w_busy_next = 1'b0;
      end
    endcase
  end

  assign TX_OUT = r_tx;
  assign busy   = r_busy;

endmodule : uart_tx_ctrl

// File: tb/tb_uart_tx_ctrl.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_ctrl
//   Directed bench for uart_tx_ctrl: reset/idle, parity and non-parity
//   frames, held Data_Valid back-to-back, asynchronous mid-frame reset and
//   post-accept input changes. Expected frames are written out by hand.
// ----------------------------------------------------------------------------
module tb_uart_tx_ctrl;

  localparam int DATA_WD = 8;

  logic               CLK;
  logic               RST;
  logic [DATA_WD-1:0] P_DATA;
  logic               Data_Valid;
  logic               PAR_EN;
  logic               par_bit;
  logic               TX_OUT;
  logic               busy;

  int n_cmp;
  int n_err;
  int exp_q[$];

  uart_tx_ctrl #(
    .DATA_WD (DATA_WD)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .par_bit    (par_bit),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Walks one frame whose accept edge (E0) is the next rising edge. Each bit
  // is sampled 1 time unit after its edge. With scramble set, Data_Valid is
  // dropped and P_DATA/PAR_EN are inverted right after accept; the frame
  // must not change. Ends by checking the idle cycle after the stop bit.
  task automatic expect_frame(input string tag, input bit scramble);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge CLK);
      #1;
      if (i == 0 && scramble) begin
        Data_Valid = 1'b0;
        P_DATA     = ~P_DATA;
        PAR_EN     = ~PAR_EN;
      end
      check($sformatf("%s_tx%0d", tag, i), 32'(TX_OUT), exp_q[i]);
      check($sformatf("%s_busy%0d", tag, i), 32'(busy), 1);
    end
    @(posedge CLK);
    #1;
    check($sformatf("%s_idle_tx", tag), 32'(TX_OUT), 1);
    check($sformatf("%s_idle_busy", tag), 32'(busy), 0);
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    RST        = 1'b1;
    P_DATA     = '0;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    par_bit    = 1'b0;

    // Reset state and quiet idle.
    #1;
    check("rst_tx", 32'(TX_OUT), 1);
    check("rst_busy", 32'(busy), 0);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      #1;
      check($sformatf("idle%0d_tx", i), 32'(TX_OUT), 1);
      check($sformatf("idle%0d_busy", i), 32'(busy), 0);
    end

    // 8'hA5 with parity, par_bit = 0: 11-cycle frame.
    @(negedge CLK);
    P_DATA = 8'hA5; PAR_EN = 1'b1; par_bit = 1'b0; Data_Valid = 1'b1;
    exp_q = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
    expect_frame("a5p", 1'b1);

    // 8'h0F without parity, par_bit held at 1: 10-cycle frame.
    @(negedge CLK);
    P_DATA = 8'h0F; PAR_EN = 1'b0; par_bit = 1'b1; Data_Valid = 1'b1;
    exp_q = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 1};
    expect_frame("0f", 1'b1);

    // Data_Valid held high: 8'h3C, data changed to 8'hFF mid-frame, one idle
    // cycle, then 8'hFF.
    @(negedge CLK);
    P_DATA = 8'h3C; PAR_EN = 1'b0; par_bit = 1'b0; Data_Valid = 1'b1;
    fork
      begin
        repeat (4) @(posedge CLK);
        #2;
        P_DATA = 8'hFF;
      end
    join_none
    exp_q = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 1};
    expect_frame("3c", 1'b0);
    exp_q = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    expect_frame("ff", 1'b1);

    // Asynchronous reset during data bit 4 of 8'h55.
    @(negedge CLK);
    P_DATA = 8'h55; PAR_EN = 1'b0; Data_Valid = 1'b1;
    @(posedge CLK);
    #1;
    Data_Valid = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    check("55_bit4_tx", 32'(TX_OUT), 1);
    check("55_bit4_busy", 32'(busy), 1);
    #2;
    RST = 1'b1;
    #1;
    check("async_rst_tx", 32'(TX_OUT), 1);
    check("async_rst_busy", 32'(busy), 0);
    // Data_Valid together with reset: reset wins.
    P_DATA = 8'h81; PAR_EN = 1'b0; Data_Valid = 1'b1;
    @(posedge CLK);
    #1;
    check("rst_dv_tx", 32'(TX_OUT), 1);
    check("rst_dv_busy", 32'(busy), 0);
    @(negedge CLK);
    RST = 1'b0;
    exp_q = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 1};
    expect_frame("81", 1'b1);

    // PAR_EN 1 at accept then dropped, par_bit = 1: parity still sent.
    @(negedge CLK);
    P_DATA = 8'hC3; PAR_EN = 1'b1; par_bit = 1'b1; Data_Valid = 1'b1;
    exp_q = '{0, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
    expect_frame("c3p", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_uart_tx_ctrl
